// File: rtl/mc_control_unit.sv
// Multi-cycle sequencer: steps IF/ID/EXE/MEM/WB/HALT and decodes datapath strobes.
// Define MCPU_BNE_EN to add bne (110101) on the beq path; otherwise that opcode is illegal.
module mc_control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [2:0] state,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       RegDst,
  output logic       RegWre,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic       illegal
);

  localparam logic [2:0] ST_IF   = 3'b000;
  localparam logic [2:0] ST_ID   = 3'b001;
  localparam logic [2:0] ST_EXE  = 3'b010;
  localparam logic [2:0] ST_MEM  = 3'b011;
  localparam logic [2:0] ST_WB   = 3'b100;
  localparam logic [2:0] ST_HALT = 3'b101;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [1:0] w_pcsrc;
  logic [2:0] w_aluop;
  logic       w_rtype, w_addi, w_ori, w_lw, w_sw, w_beq, w_bne, w_j, w_halt;
  logic       w_branch, w_mem, w_alu, w_legal, w_not_if;

  assign w_rtype  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                    (op == OP_OR)  || (op == OP_SLT);
  assign w_addi   = (op == OP_ADDI);
  assign w_ori    = (op == OP_ORI);
  assign w_lw     = (op == OP_LW);
  assign w_sw     = (op == OP_SW);
  assign w_beq    = (op == OP_BEQ);
  assign w_j      = (op == OP_J);
  assign w_halt   = (op == OP_HALT);
`ifdef MCPU_BNE_EN
  assign w_bne    = (op == OP_BNE);
`else
  assign w_bne    = 1'b0;
`endif
  assign w_branch = w_beq || w_bne;
  assign w_mem    = w_lw || w_sw;
  assign w_alu    = w_rtype || w_addi || w_ori;
  assign w_legal  = w_alu || w_mem || w_branch || w_j || w_halt;
  assign w_not_if = (r_state != ST_IF);

  // Next-state selection; unused encodings fall back to IF.
  always_comb begin
    w_next = ST_IF;
    case (r_state)
      ST_IF:   w_next = ST_ID;
      ST_ID: begin
        if (w_j)           w_next = ST_IF;
        else if (w_halt)   w_next = ST_HALT;
        else if (!w_legal) w_next = ST_IF;
        else               w_next = ST_EXE;
      end
      ST_EXE: begin
        if (w_branch)      w_next = ST_IF;
        else if (w_mem)    w_next = ST_MEM;
        else               w_next = ST_WB;
      end
      ST_MEM: begin
        if (w_lw)          w_next = ST_WB;
        else               w_next = ST_IF;
      end
      ST_WB:   w_next = ST_IF;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IF;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset) r_state <= ST_IF;
    else        r_state <= w_next;
  end

  // Next-PC source: jump target in ID, branch offset when the EXE compare is taken.
  always_comb begin
    w_pcsrc = 2'b00;
    if ((r_state == ST_ID) && w_j)
      w_pcsrc = 2'b10;
    else if ((r_state == ST_EXE) && ((w_beq && zero) || (w_bne && !zero)))
      w_pcsrc = 2'b01;
    else
      w_pcsrc = 2'b00;
  end

  // ALU function select, only meaningful while the ALU is in use.
  always_comb begin
    w_aluop = 3'b000;
    if ((r_state == ST_EXE) || (r_state == ST_MEM)) begin
      case (op)
        OP_ADD, OP_ADDI, OP_LW, OP_SW: w_aluop = 3'b000;
        OP_SUB, OP_BEQ:                w_aluop = 3'b001;
        OP_AND:                        w_aluop = 3'b010;
        OP_OR, OP_ORI:                 w_aluop = 3'b011;
        OP_SLT:                        w_aluop = 3'b101;
        default:                       w_aluop = w_bne ? 3'b001 : 3'b000;
      endcase
    end else begin
      w_aluop = 3'b000;
    end
  end

  assign state     = r_state;
  assign PCWre     = (w_next == ST_IF) && (r_state != ST_HALT);
  assign PCSrc     = w_pcsrc;
  assign IRWre     = (r_state == ST_IF);
  assign ALUSrcB   = w_not_if && (w_addi || w_ori || w_mem);
  assign ALUOp     = w_aluop;
  assign ExtSel    = w_not_if && !w_ori;
  assign RegDst    = w_not_if && w_rtype;
  assign RegWre    = (r_state == ST_WB);
  assign DBDataSrc = w_not_if && w_lw;
  assign mRD       = (r_state == ST_MEM) && w_lw;
  assign mWR       = (r_state == ST_MEM) && w_sw;
  assign illegal   = (r_state == ST_ID) && !w_legal;

endmodule
